signed_compare_pipe: RTL and testbench

//  NCH-lane, 2-stage pipelined comparator with valid/ready handshake; successor to the single-lane combinational comparator.
//  Per lane: one-hot EQ/LT/GT of A vs B (signed or unsigned, chosen per transaction) plus the selected min or max operand.

---
 rtl/signed_compare_pipe.sv | 195 +++++++++++++++++++
 tb/tb_signed_compare_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_compare_pipe.sv
// signed_compare_pipe
//   Multi-lane, two-stage pipelined comparator with a valid/ready handshake.
//   For each lane it reports one-hot EQ/LT/GT of A versus B, signed or unsigned
//   as chosen per transaction. It also returns the selected min or max operand.
//   Ordering comes from an exact (DSIZE+1)-bit difference, so operand pairs that
//   would overflow a DSIZE-bit subtract still compare correctly.
//
//   Optional feature macro: CMP_GT_CNT_EN
//     When it is defined, the cnt_clr and gt_cnt ports exist. Each lane then
//     keeps a saturating count of delivered GT results.
//     When it is undefined, those ports, the counters and CNT_W do not exist.

module signed_compare_pipe #(
    parameter int DSIZE = 16,
    parameter int NCH   = 4
`ifdef CMP_GT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_mode,
    input  logic [NCH*DSIZE-1:0]   in_a,
    input  logic [NCH*DSIZE-1:0]   in_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCH-1:0]         out_eq,
    output logic [NCH-1:0]         out_lt,
    output logic [NCH-1:0]         out_gt,
    output logic [NCH*DSIZE-1:0]   out_sel
`ifdef CMP_GT_CNT_EN
    ,
    input  logic                   cnt_clr,
    output logic [NCH*CNT_W-1:0]   gt_cnt
`endif
);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic                  s1_valid_reg;
    logic [NCH*DSIZE-1:0]  s1_a_reg;
    logic [NCH*DSIZE-1:0]  s1_b_reg;
    logic [1:0]            s1_mode_reg;

    logic                  s2_valid_reg;
    logic [NCH-1:0]        s2_eq_reg;
    logic [NCH-1:0]        s2_lt_reg;
    logic [NCH-1:0]        s2_gt_reg;
    logic [NCH*DSIZE-1:0]  s2_sel_reg;

    logic                  adv2;
    logic                  adv1;
    logic                  in_fire;
    logic                  out_fire;

    // Each stage moves when it is empty or when its successor is moving.
    // in_ready is derived only from stage state, so it never depends on in_valid.
    assign adv2     = ~s2_valid_reg | out_ready;
    assign adv1     = ~s1_valid_reg | adv2;
    assign in_ready = adv1;
    assign in_fire  = in_valid & adv1;
    assign out_fire = s2_valid_reg & out_ready;

    // ------------------------------------------------------------------
    // Stage 1: operand capture
    // ------------------------------------------------------------------
    // Stage-1 valid tracks the input whenever the stage advances. An empty input becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (adv1) begin
            s1_valid_reg <= in_valid;
        end
    end

    // Operand and mode registers load only on a real transfer. Otherwise they hold through stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_reg    <= '0;
            s1_b_reg    <= '0;
            s1_mode_reg <= 2'b00;
        end else if (in_fire) begin
            s1_a_reg    <= in_a;
            s1_b_reg    <= in_b;
            s1_mode_reg <= in_mode;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational compare, one slice per lane
    // ------------------------------------------------------------------
    logic [NCH-1:0]        eq_next;
    logic [NCH-1:0]        lt_next;
    logic [NCH-1:0]        gt_next;
    logic [NCH*DSIZE-1:0]  sel_next;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi = gi + 1) begin : g_lane
            logic [DSIZE-1:0] a_lane;
            logic [DSIZE-1:0] b_lane;
            logic [DSIZE:0]   ext_a;
            logic [DSIZE:0]   ext_b;
            logic [DSIZE:0]   diff;
            logic             eq_lane;
            logic             lt_lane;

            assign a_lane = s1_a_reg[gi*DSIZE +: DSIZE];
            assign b_lane = s1_b_reg[gi*DSIZE +: DSIZE];

            // Extend by one bit: zero for unsigned and sign for signed. This keeps
            // the difference exact, and its top bit is the true sign of A - B.
            assign ext_a = s1_mode_reg[0] ? {1'b0, a_lane} : {a_lane[DSIZE-1], a_lane};
            assign ext_b = s1_mode_reg[0] ? {1'b0, b_lane} : {b_lane[DSIZE-1], b_lane};
            assign diff  = ext_a - ext_b;

            assign eq_lane = (diff == '0);
            assign lt_lane = diff[DSIZE];

            assign eq_next[gi] = eq_lane;
            assign lt_next[gi] = lt_lane;
            assign gt_next[gi] = ~eq_lane & ~lt_lane;

            // Choose max or min. On equality both operands are identical, so either branch is correct.
            assign sel_next[gi*DSIZE +: DSIZE] = s1_mode_reg[1] ? (lt_lane ? b_lane : a_lane)
                                                                : (lt_lane ? a_lane : b_lane);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 2: result register
    // ------------------------------------------------------------------
    // Result valid takes stage-1 valid whenever the output stage advances. A stage-1 bubble therefore drains it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
        end else if (adv2) begin
            s2_valid_reg <= s1_valid_reg;
        end
    end

    // Result data loads only when a real transaction moves up. It holds during a stall or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_eq_reg  <= '0;
            s2_lt_reg  <= '0;
            s2_gt_reg  <= '0;
            s2_sel_reg <= '0;
        end else if (adv2 && s1_valid_reg) begin
            s2_eq_reg  <= eq_next;
            s2_lt_reg  <= lt_next;
            s2_gt_reg  <= gt_next;
            s2_sel_reg <= sel_next;
        end
    end

    assign out_valid = s2_valid_reg;
    assign out_eq    = s2_eq_reg;
    assign out_lt    = s2_lt_reg;
    assign out_gt    = s2_gt_reg;
    assign out_sel   = s2_sel_reg;

`ifdef CMP_GT_CNT_EN
    // ------------------------------------------------------------------
    // Per-lane saturating GT event counters
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NCH; gi = gi + 1) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Count each delivered GT result. Stop at all-ones, and let clear win over a same-cycle increment.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (cnt_clr) begin
                    cnt_reg <= '0;
                end else if (out_fire && s2_gt_reg[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign gt_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
        end
    endgenerate
`else
    // Without the counters, the output-transfer strobe has no consumer.
    logic unused_out_fire;
    assign unused_out_fire = out_fire;
`endif

endmodule

// File: tb/tb_signed_compare_pipe.sv
// Testbench for signed_compare_pipe.
// Input transfers push reference-model results into a queue. A monitor pops and
// compares each delivered output, and it also checks that held outputs stay
// stable during stalls.
// With CMP_GT_CNT_EN defined, the saturating GT counters are also exercised at CNT_W=4.

module tb_signed_compare_pipe;

    localparam int DSIZE = 16;
    localparam int NCH   = 4;
    localparam int W     = NCH * DSIZE;
`ifdef CMP_GT_CNT_EN
    localparam int CNT_W = 4;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_mode;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [NCH-1:0] out_eq;
    logic [NCH-1:0] out_lt;
    logic [NCH-1:0] out_gt;
    logic [W-1:0]   out_sel;
`ifdef CMP_GT_CNT_EN
    logic                   cnt_clr;
    logic [NCH*CNT_W-1:0]   gt_cnt;
`endif

    signed_compare_pipe #(
        .DSIZE(DSIZE),
        .NCH  (NCH)
`ifdef CMP_GT_CNT_EN
        ,
        .CNT_W(CNT_W)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_eq   (out_eq),
        .out_lt   (out_lt),
        .out_gt   (out_gt),
        .out_sel  (out_sel)
`ifdef CMP_GT_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .gt_cnt   (gt_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] eq;
        logic [NCH-1:0] lt;
        logic [NCH-1:0] gt;
        logic [W-1:0]   sel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_out  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference model: operands become plain integers, then ordinary comparison
    // gives the flags and the chosen min/max.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
        exp_t r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            logic [DSIZE-1:0] ra;
            logic [DSIZE-1:0] rb;
            longint va;
            longint vb;
            ra = a[k*DSIZE +: DSIZE];
            rb = b[k*DSIZE +: DSIZE];
            if (m[0]) begin
                va = longint'(ra);
                vb = longint'(rb);
            end else begin
                va = longint'($signed(ra));
                vb = longint'($signed(rb));
            end
            r.eq[k] = (va == vb);
            r.lt[k] = (va <  vb);
            r.gt[k] = (va >  vb);
            if (m[1]) r.sel[k*DSIZE +: DSIZE] = (va >= vb) ? ra : rb;
            else      r.sel[k*DSIZE +: DSIZE] = (va <= vb) ? ra : rb;
        end
        return r;
    endfunction

    // Monitor: records input transfers, checks output transfers and stall stability.
    logic           stall_prev = 1'b0;
    exp_t           held;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev && out_valid) begin
                chk("stall_hold_flags", {out_eq, out_lt, out_gt}, {held.eq, held.lt, held.gt});
                chk("stall_hold_sel", out_sel, held.sel);
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_mode));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("flags", {out_eq, out_lt, out_gt}, {e.eq, e.lt, e.gt});
                    chk("sel", out_sel, e.sel);
                    $display("out #%0d eq=%b lt=%b gt=%b sel=%h", n_out, out_eq, out_lt, out_gt, out_sel);
                end
                n_out++;
            end
            stall_prev = out_valid && !out_ready;
            held       = '{eq: out_eq, lt: out_lt, gt: out_gt, sel: out_sel};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Sends one transaction into an empty pipeline with out_ready=1. It checks the
    // two-edge latency, then leaves time at the point where the result is presented.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] m);
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = m;
        @(negedge clk);
        chk("send_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_not_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("latency_two_edges", 64'(out_valid), 64'd1);
    endtask

    function automatic logic [W-1:0] pack4(input logic [DSIZE-1:0] l0, input logic [DSIZE-1:0] l1,
                                           input logic [DSIZE-1:0] l2, input logic [DSIZE-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [DSIZE-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            3: return 16'h0000;
            default: return DSIZE'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] sa[3];
        logic [W-1:0] sb[3];
        logic [1:0]   sm[3];
        int n_acc;
        int n0;
        logic fire;

        rst_n = 1'b0; in_valid = 1'b0; in_mode = 2'b00; in_a = '0; in_b = '0; out_ready = 1'b1;
`ifdef CMP_GT_CNT_EN
        cnt_clr = 1'b0;
`endif
        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed signed min mix, including the most-negative vs most-positive boundary.
        send_one(pack4(16'd5, 16'hFFFD, 16'h8000, 16'd7), pack4(16'd5, 16'd2, 16'h7FFF, 16'hFFFF), 2'b00);
        chk("t2_eq", 64'(out_eq), 64'b0001);
        chk("t2_lt", 64'(out_lt), 64'b0110);
        chk("t2_gt", 64'(out_gt), 64'b1000);
        chk("t2_sel", out_sel, pack4(16'd5, 16'hFFFD, 16'h8000, 16'hFFFF));
        @(posedge clk); #1;

        // Same operands under unsigned max, then under signed max.
        send_one({NCH{16'hFFFF}}, {NCH{16'h0001}}, 2'b11);
        chk("t3u_gt", 64'(out_gt), 64'b1111);
        chk("t3u_sel", out_sel, {NCH{16'hFFFF}});
        @(posedge clk); #1;
        send_one({NCH{16'hFFFF}}, {NCH{16'h0001}}, 2'b10);
        chk("t3s_lt", 64'(out_lt), 64'b1111);
        chk("t3s_sel", out_sel, {NCH{16'h0001}});
        @(posedge clk); #1;
        send_one({NCH{16'h0000}}, {NCH{16'hFFFF}}, 2'b01);
        chk("t3u0_lt", 64'(out_lt), 64'b1111);
        @(posedge clk); #1;
        wait_drain("directed_drain");

        // 100 back-to-back random transactions with the consumer always ready.
        n0 = n_out;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1;
            in_mode  = 2'($urandom);
            for (int k = 0; k < NCH; k++) begin
                in_a[k*DSIZE +: DSIZE] = rnd_op();
                in_b[k*DSIZE +: DSIZE] = ($urandom_range(0, 3) == 0) ? in_a[k*DSIZE +: DSIZE] : rnd_op();
            end
            @(negedge clk);
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            if (c >= 2) chk("b2b_out_valid", 64'(out_valid), 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain");
        chk("b2b_count", 64'(n_out - n0), 64'd100);

        // Stall: the consumer blocks for five cycles while three transactions are offered.
        for (int i = 0; i < 3; i++) begin
            sa[i] = {$urandom, $urandom};
            sb[i] = {$urandom, $urandom};
            sm[i] = 2'($urandom);
        end
        n0 = n_out;
        out_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (n_acc < 3);
            in_a = sa[n_acc < 3 ? n_acc : 2]; in_b = sb[n_acc < 3 ? n_acc : 2]; in_mode = sm[n_acc < 3 ? n_acc : 2];
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) n_acc++;
        end
        chk("stall_accepted", 64'(n_acc), 64'd2);
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && n_acc < 3; c++) begin
            in_valid = 1'b1; in_a = sa[n_acc]; in_b = sb[n_acc]; in_mode = sm[n_acc];
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) n_acc++;
        end
        in_valid = 1'b0;
        chk("stall_all_accepted", 64'(n_acc), 64'd3);
        wait_drain("stall_drain");
        chk("stall_count", 64'(n_out - n0), 64'd3);

        // Reset mid-stream with results in flight and the consumer blocked.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = {NCH{16'h1234}}; in_b = {NCH{16'h0001}}; in_mode = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_flags", 64'({out_eq, out_lt, out_gt}), 64'd0);
        chk("midreset_sel", out_sel, 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
`ifdef CMP_GT_CNT_EN
        chk("midreset_gt_cnt", 64'(gt_cnt), 64'd0);
`endif
        exp_q.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_reset_no_output", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;

`ifdef CMP_GT_CNT_EN
        // 20 GT results on lane 0, with EQ on the other lanes, saturate the 4-bit counter at 15.
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1; in_a = pack4(16'd5, 16'd0, 16'd0, 16'd0); in_b = pack4(16'd1, 16'd0, 16'd0, 16'd0);
            in_mode = 2'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("cnt_drain");
        chk("cnt_lane0_sat", 64'(gt_cnt[CNT_W-1:0]), 64'd15);
        chk("cnt_lane1_zero", 64'(gt_cnt[2*CNT_W-1:CNT_W]), 64'd0);
        // Clear coincides with a GT delivery, and the clear must win.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) begin
            @(posedge clk); #1;
        end
        chk("cnt_gt_pending", 64'(out_valid && out_gt[0]), 64'd1);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("cnt_clear_wins", 64'(gt_cnt[CNT_W-1:0]), 64'd0);
        // After the clear, counting resumes from zero.
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("cnt_drain2");
        chk("cnt_after_clear", 64'(gt_cnt[CNT_W-1:0]), 64'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
